// File: rtl/display_scan_controller_if.sv
// Frame-load handshake and decoder-drive bundle for display_scan_controller.
//   load      : request to capture value/dp_in into the shadow frame
//   value     : one nibble per digit, digit 0 in bits [3:0]
//   dp_in     : decimal-point flag per digit
//   load_ack  : one-cycle pulse when the shadow frame becomes active
//   busy      : a captured shadow frame is waiting for the next frame boundary
//   bcd       : nibble to the shared hex-to-seven-segment decoder
//   dp        : decimal point for the digit currently selected
//   digit_sel : one-hot digit enable, active high, all zero when dark
// master = frame producer; slave = scan controller.
interface display_scan_controller_if #(
  parameter int DIGITS = 4
);
  logic                  load;
  logic [4*DIGITS-1:0]   value;
  logic [DIGITS-1:0]     dp_in;
  logic                  load_ack;
  logic                  busy;
  logic [3:0]            bcd;
  logic                  dp;
  logic [DIGITS-1:0]     digit_sel;

  modport master (
    output load, value, dp_in,
    input  load_ack, busy, bcd, dp, digit_sel
  );

  modport slave (
    input  load, value, dp_in,
    output load_ack, busy, bcd, dp, digit_sel
  );
endinterface

// File: rtl/display_scan_controller.sv
// Time-multiplexed scan of DIGITS common-cathode positions through one shared
// hex-to-seven-segment decoder. Every digit slot is BLANK_CYCLES dark clocks
// (bcd/dp settle while no digit is enabled) followed by SHOW_CYCLES lit clocks.
// New frames enter a shadow register via load/ack and are promoted to the
// active frame only on the edge that starts digit 0, so a scan never mixes
// two frames.
// Ports:
//   clk    : system clock, rising edge
//   reset  : asynchronous, active-high; clears FSM, frames and outputs
//   enable : 1 = scan runs; 0 = go dark once the current lit slot finishes
//   bus    : display_scan_controller_if.slave (load/value/dp_in in,
//            load_ack/busy/bcd/dp/digit_sel out, all outputs registered)
module display_scan_controller #(
  parameter int DIGITS       = 4,
  parameter int SHOW_CYCLES  = 1000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  display_scan_controller_if.slave    bus
);

  localparam int MAX_CYC = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
  // A one-cycle maximum would give a zero-width counter; keep at least one bit.
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int IDX_W   = $clog2(DIGITS);

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [IDX_W-1:0]      idx;

  logic [4*DIGITS-1:0]   shadow_val;
  logic [DIGITS-1:0]     shadow_dp;
  logic [4*DIGITS-1:0]   active_val;
  logic [DIGITS-1:0]     active_dp;

  logic                  busy_r;
  logic                  load_ack_r;
  logic [3:0]            bcd_r;
  logic                  dp_r;
  logic [DIGITS-1:0]     digit_sel_r;

  logic                  show_done;
  logic                  enter_d0;
  logic                  xfer;
  logic [IDX_W-1:0]      nidx;
  logic [4*DIGITS-1:0]   src_val;
  logic [DIGITS-1:0]     src_dp;
  logic [3:0]            next_bcd;
  logic                  next_dp;

  function automatic logic [DIGITS-1:0] onehot(input logic [IDX_W-1:0] i);
    onehot = {{(DIGITS-1){1'b0}}, 1'b1} << i;
  endfunction

  // Slot sequencing decisions shared by the frame and scan registers.
  // nidx is the index the next BLANK will use: idx+1 (wrapping) from SHOW,
  // 0 from IDLE. When the transfer happens on this edge, the new digit 0
  // entry comes straight from the shadow so the first lit digit is new data.
  always_comb begin
    show_done = (state == SHOW) && (cnt == SHOW_LAST);
    enter_d0  = ((state == IDLE) && enable) ||
                (show_done && enable && (idx == IDX_LAST));
    xfer      = enter_d0 && busy_r;
    nidx      = '0;
    if ((state == SHOW) && (idx != IDX_LAST))
      nidx = idx + IDX_W'(1);
    src_val   = xfer ? shadow_val : active_val;
    src_dp    = xfer ? shadow_dp  : active_dp;
    next_bcd  = src_val[{nidx, 2'b00} +: 4];
    next_dp   = src_dp[nidx];
  end

  // Shadow/active frames and the load handshake. A transfer on the same edge
  // as a load wins; the load is dropped and the requester sees busy fall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_val <= '0;
      shadow_dp  <= '0;
      active_val <= '0;
      active_dp  <= '0;
      busy_r     <= 1'b0;
      load_ack_r <= 1'b0;
    end else begin
      load_ack_r <= 1'b0;
      if (xfer) begin
        active_val <= shadow_val;
        active_dp  <= shadow_dp;
        busy_r     <= 1'b0;
        load_ack_r <= 1'b1;
      end else if (bus.load && !busy_r) begin
        shadow_val <= bus.value;
        shadow_dp  <= bus.dp_in;
        busy_r     <= 1'b1;
      end
    end
  end

  // Scan FSM. digit_sel is cleared on the same edge bcd/dp change, so the
  // decoder input only ever moves while every digit is dark.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      bcd_r       <= 4'h0;
      dp_r        <= 1'b0;
      digit_sel_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          digit_sel_r <= '0;
          if (enable) begin
            state <= BLANK;
            idx   <= '0;
            cnt   <= '0;
            bcd_r <= next_bcd;
            dp_r  <= next_dp;
          end
        end
        BLANK: begin
          if (cnt == BLANK_LAST) begin
            state       <= SHOW;
            cnt         <= '0;
            digit_sel_r <= onehot(idx);
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        SHOW: begin
          if (show_done) begin
            digit_sel_r <= '0;
            cnt         <= '0;
            if (enable) begin
              state <= BLANK;
              idx   <= nidx;
              bcd_r <= next_bcd;
              dp_r  <= next_dp;
            end else begin
              // Restart always begins at digit 0.
              state <= IDLE;
              idx   <= '0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state       <= IDLE;
          cnt         <= '0;
          idx         <= '0;
          digit_sel_r <= '0;
        end
      endcase
    end
  end

  assign bus.busy      = busy_r;
  assign bus.load_ack  = load_ack_r;
  assign bus.bcd       = bcd_r;
  assign bus.dp        = dp_r;
  assign bus.digit_sel = digit_sel_r;

endmodule

// File: tb/tb_display_scan_controller.sv
// Directed bench for display_scan_controller with DIGITS=4, SHOW_CYCLES=4,
// BLANK_CYCLES=2 (slot = 6 clocks, frame = 24 clocks). Slot records describe
// one digit slot: an optional load (at slot start or on the edge that ends
// the slot) and the expected bcd/digit_sel/dp/load_ack/busy.
module tb_display_scan_controller;

  localparam int DIGITS = 4;

  logic clk;
  logic reset;
  logic enable;
  int   checks;
  int   errors;

  display_scan_controller_if #(.DIGITS(DIGITS)) bus ();

  display_scan_controller #(
    .DIGITS(DIGITS),
    .SHOW_CYCLES(4),
    .BLANK_CYCLES(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  ld_at;  // 0 none, 1 at slot start, 2 on the edge ending the slot
    logic [15:0] val;
    logic [3:0]  dpi;
    logic [3:0]  bcd;
    logic [3:0]  sel;
    logic        dp;
    logic        ack;    // load_ack seen in the first BLANK cycle
    logic        busy;   // busy seen in the second BLANK cycle
  } slot_t;

  slot_t tbl  [17];
  slot_t tbl2 [4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Entered just after the edge that starts the slot's BLANK; leaves just
  // after the edge that starts the following slot.
  task automatic run_slot(input slot_t v);
    for (int k = 0; k < 6; k++) begin
      if (k == 0) begin
        chk("load_ack", bus.load_ack, v.ack);
        chk("blank_sel0", bus.digit_sel, 4'b0000);
        chk("blank_bcd0", bus.bcd, v.bcd);
        bus.load  = (v.ld_at == 2'd1);
        bus.value = v.val;
        bus.dp_in = v.dpi;
      end else if (k == 1) begin
        bus.load = 1'b0;
        chk("busy", bus.busy, v.busy);
        chk("blank_sel1", bus.digit_sel, 4'b0000);
        chk("blank_bcd1", bus.bcd, v.bcd);
        chk("ack_pulse", bus.load_ack, 1'b0);
      end else begin
        chk("show_sel", bus.digit_sel, v.sel);
        chk("show_bcd", bus.bcd, v.bcd);
        chk("show_dp", bus.dp, v.dp);
      end
      if (k == 5 && v.ld_at == 2'd2) begin
        bus.load  = 1'b1;
        bus.value = v.val;
        bus.dp_in = v.dpi;
      end
      tick();
    end
    bus.load = 1'b0;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    enable    = 1'b0;
    bus.load  = 1'b0;
    bus.value = 16'h0;
    bus.dp_in = 4'h0;

    //            ld_at  val       dpi      bcd   sel      dp    ack   busy
    tbl[0]  = '{2'd0, 16'h0000, 4'b0000, 4'h1, 4'b0001, 1'b0, 1'b1, 1'b0};
    tbl[1]  = '{2'd0, 16'h0000, 4'b0000, 4'h7, 4'b0010, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{2'd0, 16'h0000, 4'b0000, 4'hA, 4'b0100, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{2'd0, 16'h0000, 4'b0000, 4'h3, 4'b1000, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{2'd0, 16'h0000, 4'b0000, 4'h1, 4'b0001, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{2'd0, 16'h0000, 4'b0000, 4'h7, 4'b0010, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{2'd1, 16'h1234, 4'b0000, 4'hA, 4'b0100, 1'b0, 1'b0, 1'b1};
    tbl[7]  = '{2'd1, 16'hFFFF, 4'b1111, 4'h3, 4'b1000, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{2'd0, 16'h0000, 4'b0000, 4'h4, 4'b0001, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{2'd0, 16'h0000, 4'b0000, 4'h3, 4'b0010, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{2'd1, 16'h5555, 4'b0100, 4'h2, 4'b0100, 1'b0, 1'b0, 1'b1};
    tbl[11] = '{2'd2, 16'h6789, 4'b1111, 4'h1, 4'b1000, 1'b0, 1'b0, 1'b1};
    tbl[12] = '{2'd0, 16'h0000, 4'b0000, 4'h5, 4'b0001, 1'b0, 1'b1, 1'b0};
    tbl[13] = '{2'd0, 16'h0000, 4'b0000, 4'h5, 4'b0010, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{2'd0, 16'h0000, 4'b0000, 4'h5, 4'b0100, 1'b1, 1'b0, 1'b0};
    tbl[15] = '{2'd0, 16'h0000, 4'b0000, 4'h5, 4'b1000, 1'b0, 1'b0, 1'b0};
    tbl[16] = '{2'd0, 16'h0000, 4'b0000, 4'h5, 4'b0001, 1'b0, 1'b0, 1'b0};

    tbl2[0] = '{2'd0, 16'h0000, 4'b0000, 4'h2, 4'b0001, 1'b0, 1'b1, 1'b0};
    tbl2[1] = '{2'd0, 16'h0000, 4'b0000, 4'h4, 4'b0010, 1'b0, 1'b0, 1'b0};
    tbl2[2] = '{2'd0, 16'h0000, 4'b0000, 4'h6, 4'b0100, 1'b1, 1'b0, 1'b0};
    tbl2[3] = '{2'd0, 16'h0000, 4'b0000, 4'h8, 4'b1000, 1'b0, 1'b0, 1'b0};

    // Reset, then stay dark with enable low.
    tick();
    tick();
    chk("rst_sel", bus.digit_sel, 4'b0000);
    chk("rst_bcd", bus.bcd, 4'h0);
    chk("rst_dp", bus.dp, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_ack", bus.load_ack, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("dark_sel", bus.digit_sel, 4'b0000);
      chk("dark_bcd", bus.bcd, 4'h0);
      chk("dark_busy", bus.busy, 1'b0);
    end

    // Load 3A71 while idle, then start scanning.
    bus.load  = 1'b1;
    bus.value = 16'h3A71;
    bus.dp_in = 4'b0000;
    tick();
    bus.load = 1'b0;
    chk("load_busy", bus.busy, 1'b1);
    chk("load_noack", bus.load_ack, 1'b0);
    chk("load_dark", bus.digit_sel, 4'b0000);
    enable = 1'b1;
    tick();

    for (int i = 0; i < 17; i++) run_slot(tbl[i]);

    // Now at BLANK of digit 1; drop enable once its SHOW has begun.
    tick();
    tick();
    chk("en_off_sel", bus.digit_sel, 4'b0010);
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("finish_show", bus.digit_sel, 4'b0010);
    end
    tick();
    chk("idle_sel", bus.digit_sel, 4'b0000);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("idle_stay", bus.digit_sel, 4'b0000);
    end
    enable = 1'b1;
    tick();
    chk("resume_blank", bus.digit_sel, 4'b0000);
    chk("resume_bcd", bus.bcd, 4'h5);
    tick();
    tick();
    chk("resume_d0", bus.digit_sel, 4'b0001);

    // Pending frame, then reset in the middle of digit 2's SHOW.
    bus.load  = 1'b1;
    bus.value = 16'hABCD;
    bus.dp_in = 4'b1111;
    tick();
    bus.load = 1'b0;
    chk("pend_busy", bus.busy, 1'b1);
    for (int i = 0; i < 11; i++) tick();
    chk("pre_rst_sel", bus.digit_sel, 4'b0100);
    enable = 1'b0;
    reset  = 1'b1;
    #1;
    chk("async_sel", bus.digit_sel, 4'b0000);
    chk("async_bcd", bus.bcd, 4'h0);
    chk("async_busy", bus.busy, 1'b0);
    chk("async_dp", bus.dp, 1'b0);
    tick();
    reset = 1'b0;
    tick();
    chk("post_rst_sel", bus.digit_sel, 4'b0000);
    chk("post_rst_busy", bus.busy, 1'b0);

    // Restart with a decimal point on digit 2 only.
    bus.load  = 1'b1;
    bus.value = 16'h8642;
    bus.dp_in = 4'b0100;
    tick();
    bus.load = 1'b0;
    chk("dp_load_busy", bus.busy, 1'b1);
    enable = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) run_slot(tbl2[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
